// File: rtl/qdec_pkg.sv
// qdec_pkg: shared definitions for the quadrature decoder.
//   - step_t and the STEP_* codes: result of comparing two filtered {A,B} samples
//   - state_t: decoder FSM states (INIT while the filters prime, TRACK afterwards)
//   - decode_step(): quadrature transition lookup, (prev, cur) -> step
package qdec_pkg;

  typedef logic [1:0] step_t;

  localparam step_t STEP_NONE = 2'd0;
  localparam step_t STEP_UP   = 2'd1;
  localparam step_t STEP_DN   = 2'd2;
  localparam step_t STEP_ERR  = 2'd3;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Forward Gray sequence on {A,B} is 00 -> 10 -> 11 -> 01 -> 00.
  // Any single-bit move against that order is a reverse step; a move that
  // flips both bits cannot be resolved and is reported as an error.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t step;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_UP;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_DN;
      4'b00_00, 4'b01_01, 4'b10_10, 4'b11_11: step = STEP_NONE;
      default:                                step = STEP_ERR;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/qdecoder_if.sv
// qdecoder_if: host-side register/pulse bundle of one decoder channel.
//   clrpos, latchpos, qerrclr : one-clk command pulses from the host
//   position                  : live position counter
//   posrdata                  : position snapshot taken by latchpos
//   dir, qerr, valid          : last step direction, sticky error, decoder primed
// master = host side, slave = decoder side.
interface qdecoder_if #(
  parameter int CNTWIDTH = 16
);
  logic                clrpos;
  logic                latchpos;
  logic                qerrclr;
  logic [CNTWIDTH-1:0] position;
  logic [CNTWIDTH-1:0] posrdata;
  logic                dir;
  logic                qerr;
  logic                valid;

  modport master (
    output clrpos, latchpos, qerrclr,
    input  position, posrdata, dir, qerr, valid
  );

  modport slave (
    input  clrpos, latchpos, qerrclr,
    output position, posrdata, dir, qerr, valid
  );
endinterface

// File: rtl/qdfilter.sv
// qdfilter: conditioning for one raw encoder pin.
//   clk, resetn : clock, asynchronous active-low reset
//   filterce    : sample strobe, one clk wide
//   pin_raw     : asynchronous encoder pin
//   level       : filtered level
// The pin is brought into the clk domain by a 2-flop synchronizer. Each
// filterce shifts the synchronized level into a FILTLEN-deep history; the
// filtered level only follows once the whole history agrees, so pulses
// shorter than FILTLEN samples never reach the decoder.
module qdfilter #(
  parameter int FILTLEN = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic filterce,
  input  logic pin_raw,
  output logic level
);

  logic [1:0]         sync_q, sync_d;
  logic [FILTLEN-1:0] hist_q, hist_d;
  logic               level_q, level_d;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    sync_d  = {sync_q[0], pin_raw};
    hist_d  = hist_q;
    level_d = level_q;
    if (filterce) begin
      hist_d = {hist_q[FILTLEN-2:0], sync_q[1]};
      // Judge the history including the sample taken on this edge, so the
      // level moves on the FILTLEN-th agreeing strobe itself.
      if (&hist_d) begin
        level_d = 1'b1;
      end else if (~|hist_d) begin
        level_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      hist_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/qdecoder.sv
// qdecoder: 4x quadrature decoder for one motor channel.
//   clk, resetn : clock, asynchronous active-low reset
//   filterce    : glitch-filter sample strobe
//   invphase    : reverses the count direction
//   cntena      : count enable; the decoder keeps tracking while disabled
//   quada/quadb : raw asynchronous encoder pins
//   host        : command pulses and readback (qdecoder_if, slave side)
// The decoder waits in INIT until both filters have seen FILTLEN strobes,
// then adopts the filtered {A,B} as its reference without counting and
// tracks every clk from there on.
module qdecoder
  import qdec_pkg::*;
#(
  parameter int CNTWIDTH = 16,
  parameter int FILTLEN  = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       filterce,
  input  logic       invphase,
  input  logic       cntena,
  input  logic       quada,
  input  logic       quadb,
  qdecoder_if.slave  host
);

  localparam int             SCW       = $clog2(FILTLEN + 1);
  localparam logic [SCW-1:0] SAMP_FULL = SCW'(FILTLEN);

  logic                filt_a, filt_b;
  logic [1:0]          cur;
  step_t               step, eff_step;

  state_t              state_q, state_d;
  logic [SCW-1:0]      sampcnt_q, sampcnt_d;
  logic [1:0]          prev_q, prev_d;
  logic [CNTWIDTH-1:0] position_q, position_d;
  logic [CNTWIDTH-1:0] posrdata_q, posrdata_d;
  logic                dir_q, dir_d;
  logic                qerr_q, qerr_d;

  qdfilter #(.FILTLEN(FILTLEN)) u_filt_a (
    .clk      (clk),
    .resetn   (resetn),
    .filterce (filterce),
    .pin_raw  (quada),
    .level    (filt_a)
  );

  qdfilter #(.FILTLEN(FILTLEN)) u_filt_b (
    .clk      (clk),
    .resetn   (resetn),
    .filterce (filterce),
    .pin_raw  (quadb),
    .level    (filt_b)
  );

  assign cur  = {filt_a, filt_b};
  assign step = decode_step(prev_q, cur);

  // invphase swaps the meaning of the two directions; errors stay errors.
  always_comb begin
    eff_step = step;
    if (invphase) begin
      if (step == STEP_UP) begin
        eff_step = STEP_DN;
      end else if (step == STEP_DN) begin
        eff_step = STEP_UP;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sampcnt_d  = sampcnt_q;
    prev_d     = prev_q;
    position_d = position_q;
    posrdata_d = posrdata_q;
    dir_d      = dir_q;
    qerr_d     = qerr_q;

    if (filterce && (sampcnt_q != SAMP_FULL)) begin
      sampcnt_d = sampcnt_q + SCW'(1);
    end

    // Clear first so that an error detected in the same cycle wins.
    if (host.qerrclr) begin
      qerr_d = 1'b0;
    end

    unique case (state_q)
      INIT: begin
        if (sampcnt_q == SAMP_FULL) begin
          prev_d  = cur;
          state_d = TRACK;
        end
      end
      TRACK: begin
        prev_d = cur;
        if (eff_step == STEP_ERR) begin
          qerr_d = 1'b1;
        end else if (cntena && (eff_step == STEP_UP)) begin
          position_d = position_q + CNTWIDTH'(1);
          dir_d      = 1'b1;
        end else if (cntena && (eff_step == STEP_DN)) begin
          position_d = position_q - CNTWIDTH'(1);
          dir_d      = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase

    if (host.clrpos) begin
      position_d = '0;
    end

    // Snapshot the register value from before this edge's update.
    if (host.latchpos) begin
      posrdata_d = position_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= INIT;
      sampcnt_q  <= '0;
      prev_q     <= '0;
      position_q <= '0;
      posrdata_q <= '0;
      dir_q      <= 1'b0;
      qerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sampcnt_q  <= sampcnt_d;
      prev_q     <= prev_d;
      position_q <= position_d;
      posrdata_q <= posrdata_d;
      dir_q      <= dir_d;
      qerr_q     <= qerr_d;
    end
  end

  assign host.position = position_q;
  assign host.posrdata = posrdata_q;
  assign host.dir      = dir_q;
  assign host.qerr     = qerr_q;
  assign host.valid    = (state_q == TRACK);

endmodule
